// File: rtl/xbus_pkg.sv
// Shared types and constants for the peripheral-bus controller: FSM state,
// default page map, error data and status-word layout.
package xbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam logic [7:0]  GPIO_PAGE    = 8'h40;
  localparam logic [7:0]  SPI_PAGE     = 8'h50;
  localparam logic [7:0]  UART_PAGE    = 8'h60;
  localparam logic [7:0]  SPARE_PAGE   = 8'h70;
  localparam logic [7:0]  STAT_PAGE    = 8'hF0;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  localparam int STAT_PAGE_LSB  = 0;
  localparam int STAT_FAULT_BIT = 16;
  localparam int STAT_CNT_LSB   = 24;

  function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                              input logic       flag,
                                              input logic [7:0] pg);
    logic [31:0] word;
    word                        = '0;
    word[STAT_CNT_LSB +: 8]     = cnt;
    word[STAT_FAULT_BIT]        = flag;
    word[STAT_PAGE_LSB +: 8]    = pg;
    return word;
  endfunction

endpackage

// File: rtl/xbus_decode.sv
// Combinational page decoder: one-hot slot select plus slot-hit and
// status-page flags.
module xbus_decode import xbus_pkg::*; #(
  parameter int                AWIDTH     = 8,
  parameter logic [AWIDTH-1:0] SLOT0_ADDR = AWIDTH'(GPIO_PAGE),
  parameter logic [AWIDTH-1:0] SLOT1_ADDR = AWIDTH'(SPI_PAGE),
  parameter logic [AWIDTH-1:0] SLOT2_ADDR = AWIDTH'(UART_PAGE),
  parameter logic [AWIDTH-1:0] SLOT3_ADDR = AWIDTH'(SPARE_PAGE),
  parameter logic [AWIDTH-1:0] STAT_ADDR  = AWIDTH'(STAT_PAGE)
) (
  input  logic [AWIDTH-1:0] page,
  output logic [3:0]        sel,
  output logic              hit,
  output logic              stat
);

  assign sel  = {page == SLOT3_ADDR, page == SLOT2_ADDR,
                 page == SLOT1_ADDR, page == SLOT0_ADDR};
  assign hit  = |sel;
  assign stat = (page == STAT_ADDR);

endmodule

// File: rtl/xbus_ctrl.sv
// Wishbone peripheral-bus controller: routes SERV data-bus accesses to one of
// four IO slots, bounds each access with a timeout and keeps a fault log.
module xbus_ctrl import xbus_pkg::*; #(
  parameter int                AWIDTH     = 8,
  parameter logic [AWIDTH-1:0] SLOT0_ADDR = AWIDTH'(GPIO_PAGE),
  parameter logic [AWIDTH-1:0] SLOT1_ADDR = AWIDTH'(SPI_PAGE),
  parameter logic [AWIDTH-1:0] SLOT2_ADDR = AWIDTH'(UART_PAGE),
  parameter logic [AWIDTH-1:0] SLOT3_ADDR = AWIDTH'(SPARE_PAGE),
  parameter logic [AWIDTH-1:0] STAT_ADDR  = AWIDTH'(STAT_PAGE),
  parameter int                TIMEOUT    = 16,
  parameter logic [31:0]       ERR_DATA   = ERR_DATA_DEF
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic [31:0]  wb_dbus_adr,
  input  logic [31:0]  wb_dbus_dat,
  input  logic         wb_dbus_we,
  input  logic         wb_dbus_cyc,
  output logic [31:0]  wb_xbus_rdt,
  output logic         wb_xbus_ack,
  output logic [3:0]   slot_cyc,
  input  logic [3:0]   slot_ack,
  input  logic [127:0] slot_rdt,
  output logic         fault
);

  state_t            state, next_state;
  logic [AWIDTH-1:0] page, page_q;
  logic [3:0]        dec_sel, sel_q;
  logic              dec_hit, dec_stat;
  logic              stat_q, we_q;
  logic [7:0]        timer;
  logic [31:0]       rdt_q;
  logic [7:0]        fault_cnt, fault_page;
  logic              sel_ack, timeout, fault_event;
  logic [31:0]       sel_rdt;

  // Write data and the in-page offset are not routed by this block.
  logic unused_bits;
  assign unused_bits = ^{wb_dbus_dat, wb_dbus_adr[31-AWIDTH:0]};

  assign page = wb_dbus_adr[31 -: AWIDTH];

  xbus_decode #(
    .AWIDTH    (AWIDTH),
    .SLOT0_ADDR(SLOT0_ADDR),
    .SLOT1_ADDR(SLOT1_ADDR),
    .SLOT2_ADDR(SLOT2_ADDR),
    .SLOT3_ADDR(SLOT3_ADDR),
    .STAT_ADDR (STAT_ADDR)
  ) u_decode (
    .page(page),
    .sel (dec_sel),
    .hit (dec_hit),
    .stat(dec_stat)
  );

  // Only the selected slot's ack/data can reach the CPU.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    sel_ack = 1'b0;
    sel_rdt = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i]) begin
        sel_ack = sel_ack | slot_ack[i];
        sel_rdt = sel_rdt | slot_rdt[32*i +: 32];
      end
    end
  end

  assign timeout     = (timer == 8'(TIMEOUT - 1));
  assign fault_event = (state == ST_IDLE && wb_dbus_cyc && !dec_hit && !dec_stat) ||
                       (state == ST_WAIT && wb_dbus_cyc && !sel_ack && timeout);

  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (wb_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (wb_dbus_cyc) next_state = dec_hit ? ST_WAIT : ST_RESP;
      ST_WAIT: begin
        if (!wb_dbus_cyc)           next_state = ST_IDLE;
        else if (sel_ack || timeout) next_state = ST_RESP;
      end
      ST_RESP: next_state = ST_DONE;
      ST_DONE: if (!wb_dbus_cyc) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_cyc    = (state == ST_WAIT) ? sel_q : 4'b0000;
    wb_xbus_ack = (state == ST_RESP);
    wb_xbus_rdt = wb_xbus_ack ? rdt_q : 32'h0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      page_q <= '0;
      sel_q  <= '0;
      stat_q <= 1'b0;
      we_q   <= 1'b0;
      timer  <= '0;
      rdt_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (wb_dbus_cyc) begin
          page_q <= page;
          sel_q  <= dec_sel;
          stat_q <= dec_stat;
          we_q   <= wb_dbus_we;
          timer  <= '0;
          rdt_q  <= dec_stat ? status_word(fault_cnt, fault, fault_page) : ERR_DATA;
        end
        ST_WAIT: begin
          timer <= timer + 8'd1;
          if (sel_ack)      rdt_q <= sel_rdt;
          else if (timeout) rdt_q <= ERR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Fault log; a status-page write clears it as the ack goes out.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || (state == ST_RESP && stat_q && we_q)) begin
      fault      <= 1'b0;
      fault_cnt  <= '0;
      fault_page <= '0;
    end else if (fault_event) begin
      fault      <= 1'b1;
      fault_page <= (state == ST_IDLE) ? 8'(page) : 8'(page_q);
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end
  end

endmodule
